// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between the control unit and the sequential divider
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring unsigned divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_w, q_n;
  logic [WIDTH:0]   r_w, r_n;
  logic [WIDTH-1:0] d_w, d_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] quot, quot_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             dz, dz_n;
  logic [WIDTH:0]   r_t, r_sub;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q_w   <= '0;
      r_w   <= '0;
      d_w   <= '0;
      cnt   <= '0;
      quot  <= '0;
      rem   <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      q_w   <= q_n;
      r_w   <= r_n;
      d_w   <= d_n;
      cnt   <= cnt_n;
      quot  <= quot_n;
      rem   <= rem_n;
      dz    <= dz_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q_w;
    r_n     = r_w;
    d_n     = d_w;
    cnt_n   = cnt;
    quot_n  = quot;
    rem_n   = rem;
    dz_n    = dz;
    // partial remainder is WIDTH+1 bits so the compare never overflows
    r_t     = {r_w[WIDTH-1:0], q_w[WIDTH-1]};
    r_sub   = r_t - {1'b0, d_w};
    case (state)
      RUN: begin
        if (r_t >= {1'b0, d_w}) begin
          r_n = r_sub;
          q_n = {q_w[WIDTH-2:0], 1'b1};
        end else begin
          r_n = r_t;
          q_n = {q_w[WIDTH-2:0], 1'b0};
        end
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n = FIN;
          quot_n  = q_n;
          rem_n   = r_n[WIDTH-1:0];
          dz_n    = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        if (bus.start) begin
          q_n   = bus.dividend;
          r_n   = '0;
          d_n   = bus.divisor;
          cnt_n = '0;
          if (bus.divisor == '0) begin
            // zero divisor skips the iterations and completes immediately
            state_n = FIN;
            quot_n  = '1;
            rem_n   = bus.dividend;
            dz_n    = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
    endcase
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == FIN);
  assign bus.quotient    = quot;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider against an arithmetic reference model
module tb_seq_divider;
  localparam int W = 8;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.dz = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dz = 0;
    end
    return e;
  endfunction

  // monitor: every DONE must match the oldest outstanding request
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'(bus.quotient), e.q);
        check("remainder", int'(bus.remainder), e.r);
        check("div_by_zero", int'(bus.div_by_zero), e.dz);
        if (e.b != 0) begin
          check("invariant", int'(bus.quotient) * e.b + int'(bus.remainder), e.a);
          check("rem_lt_div", int'(int'(bus.remainder) < e.b), 1);
        end
      end
    end
  end

  task automatic issue(input int a, input int b, input bit expect_it);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    if (expect_it) sb.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_quot", int'(bus.quotient), 0);
    check("rst_rem", int'(bus.remainder), 0);
    check("rst_dz", int'(bus.div_by_zero), 0);

    // 100/7 latency: BUSY for exactly WIDTH cycles, then DONE
    issue(100, 7, 1'b1);
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 50) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("latency_busy", busy_cycles, W);
    check("latency_done", int'(bus.done), 1);
    @(negedge clk);
    check("done_one_cycle", int'(bus.done), 0);
    check("held_quot", int'(bus.quotient), 14);

    issue(255, 1, 1'b1);   wait_done(40);
    issue(5, 9, 1'b1);     wait_done(40);
    issue(255, 255, 1'b1); wait_done(40);
    issue(200, 16, 1'b1);  wait_done(40);

    issue(42, 0, 1'b1);
    check("dz_no_busy", int'(bus.busy), 0);
    check("dz_done_next", int'(bus.done), 1);
    issue(10, 3, 1'b1);    wait_done(40);

    // START mid-RUN must be ignored
    issue(100, 7, 1'b1);
    idle_cycles(2);
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40);
    idle_cycles(15);

    // reset during the 4th RUN cycle aborts with no DONE
    issue(100, 7, 1'b0);
    idle_cycles(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_quot", int'(bus.quotient), 0);
    check("abort_rem", int'(bus.remainder), 0);
    idle_cycles(15);
    issue(77, 8, 1'b1);    wait_done(40);

    // back-to-back: START held high through FIN
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd77; bus.divisor = 8'd5;
    sb.push_back(model(77, 5));
    @(negedge clk);
    wait_done(40);
    bus.dividend = 8'd60; bus.divisor = 8'd6;
    sb.push_back(model(60, 6));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", int'(bus.busy), 1);
    wait_done(40);

    for (int i = 0; i < 1500; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
      issue(a, b, 1'b1);
      wait_done(40);
    end

    idle_cycles(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
